// File: rtl/bit_addr_ram_pkg.sv
// Shared encodings for the bit-addressable RAM: access mode, bit-write ops and bit-read ops.
package bit_addr_ram_pkg;

  typedef enum logic {
    MODE_BYTE = 1'b0,
    MODE_BIT  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    BIT_OP_WR  = 2'b00,
    BIT_OP_SET = 2'b01,
    BIT_OP_CLR = 2'b10,
    BIT_OP_CPL = 2'b11
  } bit_op_e;

  typedef enum logic [1:0] {
    BIT_RD    = 2'b00,
    BIT_RDCLR = 2'b01
  } bit_rd_e;

endpackage

// File: rtl/bit_addr_ram_if.sv
// Request/response bundle between the execute stage (master) and the bit-addressable RAM (slave).
interface bit_addr_ram_if #(
  parameter int WIDTH  = 8,
  parameter int BIT_AW = 7
);
  logic              CS;
  logic              RW;
  logic              mode;
  logic [1:0]        op;
  logic [BIT_AW-1:0] addr;
  logic [WIDTH-1:0]  din;
  logic [WIDTH-1:0]  dout;
  logic              dout_vld;
  logic              addr_err;

  modport master (
    output CS, RW, mode, op, addr, din,
    input  dout, dout_vld, addr_err
  );

  modport slave (
    input  CS, RW, mode, op, addr, din,
    output dout, dout_vld, addr_err
  );
endinterface

// File: rtl/bit_addr_ram_bit_op_unit.sv
// Combinational read-modify-write of one bit inside a word: write, set, clear or complement.
module bit_op_unit
  import bit_addr_ram_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int BIT_IW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]  i_old_word,
  input  logic [BIT_IW-1:0] i_bit_idx,
  input  bit_op_e           i_op,
  input  logic              i_din,
  output logic [WIDTH-1:0]  o_new_word
);

  always_comb begin
    // NOTE: the default comes first and is then patched with blocking assignments, so no latch is inferred.
    o_new_word = i_old_word;
    case (i_op)
      BIT_OP_WR:  o_new_word[i_bit_idx] = i_din;
      BIT_OP_SET: o_new_word[i_bit_idx] = 1'b1;
      BIT_OP_CLR: o_new_word[i_bit_idx] = 1'b0;
      BIT_OP_CPL: o_new_word[i_bit_idx] = ~i_old_word[i_bit_idx];
      default:    o_new_word = i_old_word;
    endcase
  end

endmodule

// File: rtl/bit_addr_ram.sv
// Bit-addressable data RAM (8051 20h-2Fh area): byte and single-bit access on one flop array,
// with atomic SETB/CLR/CPL and read-and-clear for JBC.
module bit_addr_ram
  import bit_addr_ram_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int BYTES   = 16,
  parameter int BYTE_AW = $clog2(BYTES),
  parameter int BIT_AW  = BYTE_AW + $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  bit_addr_ram_if.slave bus
);

  localparam int BIT_IW = $clog2(WIDTH);

  logic [WIDTH-1:0]   r_mem [BYTES];
  logic [WIDTH-1:0]   r_dout;
  logic               r_dout_vld;
  logic               r_addr_err;

  logic               w_access;
  logic               w_is_read;
  logic               w_is_bit;
  logic               w_in_range;
  logic               w_mem_we;
  logic [BYTE_AW-1:0] w_word;
  logic [BIT_IW-1:0]  w_bit;
  logic [WIDTH-1:0]   w_old;
  logic [WIDTH-1:0]   w_bit_new;
  logic [WIDTH-1:0]   w_new;
  logic [WIDTH-1:0]   w_rdata;
  bit_op_e            w_unit_op;

  always_comb begin
    w_access   = ~bus.CS;
    w_is_read  = bus.RW;
    w_is_bit   = (bus.mode == MODE_BIT);
    w_word     = w_is_bit ? bus.addr[BIT_AW-1:BIT_IW] : bus.addr[BYTE_AW-1:0];
    w_bit      = bus.addr[BIT_IW-1:0];
    w_in_range = int'(w_word) < BYTES;
    w_old      = w_in_range ? r_mem[w_word] : '0;

    // JBC reuses the clear path; reserved read ops never modify memory.
    if (w_is_read) w_unit_op = BIT_OP_CLR;
    else           w_unit_op = bit_op_e'(bus.op);

    w_mem_we = w_access && w_in_range &&
               (!w_is_read || (w_is_bit && bus.op == BIT_RDCLR));

    w_new = w_is_bit ? w_bit_new : bus.din;

    if (!w_in_range)   w_rdata = '0;
    else if (w_is_bit) w_rdata = WIDTH'(w_old[w_bit]);
    else               w_rdata = w_old;
  end

  bit_op_unit #(
    .WIDTH  (WIDTH),
    .BIT_IW (BIT_IW)
  ) u_bit_op (
    .i_old_word (w_old),
    .i_bit_idx  (w_bit),
    .i_op       (w_unit_op),
    .i_din      (bus.din[0]),
    .o_new_word (w_bit_new)
  );

  // NOTE: the array is reset together with the output flops; it is flops, not a RAM macro, so this is legal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BYTES; i++) r_mem[i] <= '0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
      r_dout_vld <= w_access && w_is_read;
      r_addr_err <= w_access && !w_in_range;
      if (w_access && w_is_read) r_dout <= w_rdata;
      if (w_mem_we)              r_mem[w_word] <= w_new;
    end
  end

  assign bus.dout     = r_dout;
  assign bus.dout_vld = r_dout_vld;
  assign bus.addr_err = r_addr_err;

endmodule

// File: tb/tb_bit_addr_ram.sv
// Scoreboard bench: a 16-word and a 12-word instance, expectations from a behavioural model.
module tb_bit_addr_ram;

  typedef struct packed {
    logic       vld;
    logic       err;
    logic [7:0] dout;
  } exp_t;

  logic clk;
  logic rst_n;

  bit_addr_ram_if #(.WIDTH(8), .BIT_AW(7)) if16 ();
  bit_addr_ram_if #(.WIDTH(8), .BIT_AW(7)) if12 ();

  bit_addr_ram #(.WIDTH(8), .BYTES(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  bit_addr_ram #(.WIDTH(8), .BYTES(12)) dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if12)
  );

  int         n_cmp = 0;
  int         n_mis = 0;
  exp_t       q16[$];
  exp_t       q12[$];
  exp_t       mon_e16;
  exp_t       mon_e12;
  logic [7:0] mem_m [2][16];
  logic [7:0] last_dout [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: one expectation per driven cycle, compared just after the edge that samples it.
  always @(posedge clk) begin
    #1;
    if (q16.size() > 0) begin
      mon_e16 = q16.pop_front();
      n_cmp++;
      if ({if16.dout_vld, if16.addr_err, if16.dout} !== mon_e16) begin
        n_mis++;
        $display("FAIL sb16 @%0t: got vld=%b err=%b dout=%h, required vld=%b err=%b dout=%h",
                 $time, if16.dout_vld, if16.addr_err, if16.dout, mon_e16.vld, mon_e16.err, mon_e16.dout);
      end
    end
    if (q12.size() > 0) begin
      mon_e12 = q12.pop_front();
      n_cmp++;
      if ({if12.dout_vld, if12.addr_err, if12.dout} !== mon_e12) begin
        n_mis++;
        $display("FAIL sb12 @%0t: got vld=%b err=%b dout=%h, required vld=%b err=%b dout=%h",
                 $time, if12.dout_vld, if12.addr_err, if12.dout, mon_e12.vld, mon_e12.err, mon_e12.dout);
      end
    end
  end

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 16; w++) mem_m[s][w] = 8'h00;
      last_dout[s] = 8'h00;
    end
  endtask

  task automatic model_access(input bit sel, input bit rw, input bit md, input logic [1:0] op,
                              input logic [6:0] addr, input logic [7:0] din, output exp_t e);
    int nb;
    int word;
    int b;
    nb   = sel ? 12 : 16;
    word = md ? int'(addr[6:3]) : int'(addr[3:0]);
    b    = int'(addr[2:0]);
    e.vld  = rw;
    e.err  = (word >= nb);
    e.dout = last_dout[sel];
    if (word >= nb) begin
      if (rw) e.dout = 8'h00;
    end else if (rw) begin
      if (!md) e.dout = mem_m[sel][word];
      else begin
        e.dout = {7'b0, mem_m[sel][word][b]};
        if (op == 2'b01) mem_m[sel][word][b] = 1'b0;
      end
    end else if (!md) begin
      mem_m[sel][word] = din;
    end else begin
      case (op)
        2'b00: mem_m[sel][word][b] = din[0];
        2'b01: mem_m[sel][word][b] = 1'b1;
        2'b10: mem_m[sel][word][b] = 1'b0;
        default: mem_m[sel][word][b] = ~mem_m[sel][word][b];
      endcase
    end
    last_dout[sel] = e.dout;
  endtask

  task automatic drive(input bit sel, input bit rw, input bit md, input logic [1:0] op,
                       input logic [6:0] addr, input logic [7:0] din);
    exp_t e_act;
    exp_t e_idle;
    @(negedge clk);
    if (!sel) begin
      if16.CS = 1'b0; if16.RW = rw; if16.mode = md; if16.op = op; if16.addr = addr; if16.din = din;
      if12.CS = 1'b1;
    end else begin
      if12.CS = 1'b0; if12.RW = rw; if12.mode = md; if12.op = op; if12.addr = addr; if12.din = din;
      if16.CS = 1'b1;
    end
    model_access(sel, rw, md, op, addr, din, e_act);
    e_idle = {1'b0, 1'b0, last_dout[!sel]};
    if (!sel) begin q16.push_back(e_act); q12.push_back(e_idle); end
    else      begin q12.push_back(e_act); q16.push_back(e_idle); end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if16.CS = 1'b1;
      if12.CS = 1'b1;
      q16.push_back({1'b0, 1'b0, last_dout[0]});
      q12.push_back({1'b0, 1'b0, last_dout[1]});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp += 2;
    if ({if16.dout_vld, if16.addr_err, if16.dout} !== 10'h0) begin
      n_mis++;
      $display("FAIL reset16: got vld=%b err=%b dout=%h, required all 0", if16.dout_vld, if16.addr_err, if16.dout);
    end
    if ({if12.dout_vld, if12.addr_err, if12.dout} !== 10'h0) begin
      n_mis++;
      $display("FAIL reset12: got vld=%b err=%b dout=%h, required all 0", if12.dout_vld, if12.addr_err, if12.dout);
    end
    model_clear();
    rst_n = 1'b1;
    for (int w = 0; w < 16; w++) drive(0, 1, 0, 2'b00, 7'(w), 8'h00);
    idle(1);
  endtask

  task automatic test_byte_bit_set();
    drive(0, 0, 0, 2'b00, 7'h03, 8'hA5);
    drive(0, 0, 1, 2'b01, 7'h19, 8'h00);
    drive(0, 1, 0, 2'b00, 7'h03, 8'h00);
    drive(0, 1, 1, 2'b00, 7'h19, 8'h00);
    drive(0, 1, 1, 2'b00, 7'h1E, 8'h00);
    idle(2);
  endtask

  task automatic test_cpl();
    drive(0, 0, 1, 2'b11, 7'h7F, 8'h00);
    drive(0, 1, 0, 2'b00, 7'h0F, 8'h00);
    drive(0, 0, 1, 2'b11, 7'h7F, 8'h00);
    drive(0, 1, 0, 2'b00, 7'h0F, 8'h00);
    drive(0, 1, 0, 2'b00, 7'h0E, 8'h00);
    drive(0, 1, 0, 2'b00, 7'h03, 8'h00);
    idle(1);
  endtask

  task automatic test_jbc();
    drive(0, 0, 1, 2'b00, 7'h42, 8'hFF);
    drive(0, 1, 1, 2'b01, 7'h42, 8'h00);
    drive(0, 1, 1, 2'b00, 7'h42, 8'h00);
    drive(0, 1, 0, 2'b00, 7'h08, 8'h00);
    drive(0, 0, 0, 2'b00, 7'h09, 8'hFF);
    drive(0, 0, 1, 2'b10, 7'h4D, 8'h00);
    drive(0, 0, 1, 2'b00, 7'h48, 8'hFE);
    drive(0, 1, 1, 2'b10, 7'h4F, 8'h00);
    drive(0, 1, 1, 2'b11, 7'h4F, 8'h00);
    drive(0, 1, 0, 2'b00, 7'h09, 8'h00);
    idle(1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 200; k++)
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
    for (int w = 0; w < 16; w++) drive(0, 1, 0, 2'b00, 7'(w), 8'h00);
    idle(1);
  endtask

  task automatic test_out_of_range();
    drive(1, 0, 0, 2'b00, 7'h0B, 8'h3C);
    drive(1, 1, 0, 2'b00, 7'h0B, 8'h00);
    drive(1, 0, 0, 2'b00, 7'h0D, 8'hFF);
    drive(1, 1, 0, 2'b00, 7'h0D, 8'h00);
    drive(1, 0, 1, 2'b01, 7'h5F, 8'h00);
    drive(1, 1, 0, 2'b00, 7'h0B, 8'h00);
    drive(1, 1, 1, 2'b00, 7'h68, 8'h00);
    drive(1, 0, 1, 2'b01, 7'h60, 8'h00);
    drive(1, 1, 1, 2'b01, 7'h7F, 8'h00);
    drive(1, 1, 0, 2'b00, 7'h05, 8'h00);
    drive(1, 1, 0, 2'b00, 7'h0B, 8'h00);
    idle(2);
  endtask

  task automatic test_reset_mid_burst();
    drive(0, 0, 0, 2'b00, 7'h03, 8'h5A);
    drive(1, 0, 0, 2'b00, 7'h02, 8'hC3);
    drive(1, 1, 0, 2'b00, 7'h02, 8'h00);
    drive(0, 1, 0, 2'b00, 7'h03, 8'h00);
    @(posedge clk);
    #3;
    rst_n   = 1'b0;
    if16.CS = 1'b1;
    if12.CS = 1'b1;
    #1;
    n_cmp += 2;
    if ({if16.dout_vld, if16.addr_err, if16.dout} !== 10'h0) begin
      n_mis++;
      $display("FAIL midrst16: got vld=%b err=%b dout=%h, required all 0", if16.dout_vld, if16.addr_err, if16.dout);
    end
    if ({if12.dout_vld, if12.addr_err, if12.dout} !== 10'h0) begin
      n_mis++;
      $display("FAIL midrst12: got vld=%b err=%b dout=%h, required all 0", if12.dout_vld, if12.addr_err, if12.dout);
    end
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 0, 2'b00, 7'h03, 8'h00);
    drive(0, 1, 1, 2'b00, 7'h7F, 8'h00);
    drive(1, 1, 0, 2'b00, 7'h02, 8'h00);
    drive(1, 1, 0, 2'b00, 7'h0B, 8'h00);
    idle(2);
  endtask

  initial begin
    if16.CS = 1'b1; if16.RW = 1'b1; if16.mode = 1'b0; if16.op = 2'b00; if16.addr = '0; if16.din = '0;
    if12.CS = 1'b1; if12.RW = 1'b1; if12.mode = 1'b0; if12.op = 2'b00; if12.addr = '0; if12.din = '0;
    model_clear();

    test_reset();
    test_byte_bit_set();
    test_cpl();
    test_jbc();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_burst();

    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (q16.size() + q12.size() !== 0) begin
      n_mis++;
      $display("FAIL drain: got %0d pending expectations, required 0", q16.size() + q12.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
